// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with one shared period counter.
//
// NUM_CH channels compare a shared WIDTH-bit counter against per-channel duty
// values. The counter runs in edge-aligned mode (0..P, then back to 0) or in
// center-aligned mode (0..P..1, then back to 0). Duty, period and mode are
// double-buffered: writes land in staging registers, and the active copies
// reload only at a period boundary (or continuously while disabled), so an
// update never cuts a period short or produces a runt pulse.
//
// Register map (AW-bit address):
//   0 .. NUM_CH-1 : duty staging, channel i
//   NUM_CH        : period staging P
//   NUM_CH+1      : control, bit0 = enable, bit1 = mode (0 edge, 1 center)
//   other         : writes ignored, reads return 0
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   wr_en       register write strobe
//   wr_addr     register write address
//   wr_data     register write data
//   rd_addr     readback address
//   rd_data     staging register at rd_addr, one cycle later
//   pwm_out     registered PWM outputs, one per channel
//   period_tick one-cycle pulse in the first cycle of each period
module pwm_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int AW     = $clog2(NUM_CH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [AW-1:0]    ADDR_PERIOD = AW'(NUM_CH);
    localparam logic [AW-1:0]    ADDR_CTRL   = AW'(NUM_CH + 1);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    // Staging registers (software-visible) and their next values.
    logic [WIDTH-1:0] duty_stg     [NUM_CH];
    logic [WIDTH-1:0] duty_stg_nxt [NUM_CH];
    logic [WIDTH-1:0] period_stg;
    logic [WIDTH-1:0] period_stg_nxt;
    logic             ctrl_en;
    logic             ctrl_en_nxt;
    logic             ctrl_mode;
    logic             ctrl_mode_nxt;

    // Active copies used by the counter and comparators.
    logic [WIDTH-1:0] duty_act [NUM_CH];
    logic [WIDTH-1:0] period_act;
    logic             mode_act;

    // Shared counter; dir = 1 means counting down (center mode only).
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             boundary;
    logic             load_act;

    logic [WIDTH-1:0] rd_mux;

    // Staging-next view: a write in this cycle is visible here, so an active
    // reload on the same edge picks it up.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_stg_nxt[i] = duty_stg[i];
            if (wr_en && (wr_addr == AW'(i))) begin
                duty_stg_nxt[i] = wr_data;
            end
        end

        period_stg_nxt = period_stg;
        if (wr_en && (wr_addr == ADDR_PERIOD)) begin
            period_stg_nxt = wr_data;
        end

        ctrl_en_nxt   = ctrl_en;
        ctrl_mode_nxt = ctrl_mode;
        if (wr_en && (wr_addr == ADDR_CTRL)) begin
            ctrl_en_nxt   = wr_data[0];
            ctrl_mode_nxt = wr_data[1];
        end
    end

    // Next counter state. Disabled or P = 0 parks the counter at 0/up, which
    // also makes every edge a boundary.
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        if (ctrl_en && (period_act != '0)) begin
            if (!mode_act) begin
                cnt_nxt = (cnt >= period_act) ? '0 : cnt + ONE;
            end else if (!dir) begin
                if (cnt >= period_act) begin
                    // Peak reached: turn around. With P = 1 the descent is
                    // already at 0, so direction goes straight back to up.
                    cnt_nxt = period_act - ONE;
                    dir_nxt = (period_act != ONE);
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else begin
                if (cnt <= ONE) begin
                    cnt_nxt = '0;
                    dir_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - ONE;
                    dir_nxt = 1'b1;
                end
            end
        end
    end

    assign boundary = (cnt_nxt == '0);
    assign load_act = boundary || !ctrl_en;

    // Readback mux over the current staging registers.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_mux = duty_stg[i];
            end
        end
        if (rd_addr == ADDR_PERIOD) begin
            rd_mux = period_stg;
        end
        if (rd_addr == ADDR_CTRL) begin
            rd_mux[1:0] = {ctrl_mode, ctrl_en};
        end
    end

    // Register stage: staging/active update, counter advance, compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_stg[i] <= '0;
                duty_act[i] <= '0;
            end
            period_stg  <= '1;
            period_act  <= '1;
            ctrl_en     <= 1'b0;
            ctrl_mode   <= 1'b0;
            mode_act    <= 1'b0;
            cnt         <= '0;
            dir         <= 1'b0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            rd_data     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_stg[i] <= duty_stg_nxt[i];
                if (load_act) begin
                    duty_act[i] <= duty_stg_nxt[i];
                end
                // Compare uses the current count, so outputs trail cnt by one.
                pwm_out[i] <= ctrl_en && (cnt < duty_act[i]);
            end
            period_stg <= period_stg_nxt;
            ctrl_en    <= ctrl_en_nxt;
            ctrl_mode  <= ctrl_mode_nxt;
            if (load_act) begin
                period_act <= period_stg_nxt;
                mode_act   <= ctrl_mode_nxt;
            end
            cnt         <= cnt_nxt;
            dir         <= dir_nxt;
            period_tick <= ctrl_en && boundary;
            rd_data     <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios plus randomized
// register traffic, checked every cycle against a phase-based reference model.
module tb_pwm_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [AW-1:0]     rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    int checks = 0;
    int errors = 0;

    pwm_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // Reference model: position in the period is a phase index 0..len-1;
    // the counter value is derived from the phase arithmetically.
    int m_duty_stg [NUM_CH];
    int m_duty_act [NUM_CH];
    int m_per_stg, m_per_act;
    bit m_en, m_mode_stg, m_mode_act;
    int m_phase;
    logic [NUM_CH-1:0] m_pwm;
    logic m_tick;
    logic [WIDTH-1:0] m_rd;

    function automatic int m_len();
        if (m_per_act == 0) return 1;
        return m_mode_act ? 2 * m_per_act : m_per_act + 1;
    endfunction

    function automatic int m_cnt();
        if (!m_mode_act) return m_phase;
        return (m_phase <= m_per_act) ? m_phase : 2 * m_per_act - m_phase;
    endfunction

    function automatic int m_read(input int a);
        if (a < NUM_CH) return m_duty_stg[a];
        if (a == NUM_CH) return m_per_stg;
        if (a == NUM_CH + 1) return {m_mode_stg, m_en};
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty_stg[i] = 0;
            m_duty_act[i] = 0;
        end
        m_per_stg = 255; m_per_act = 255;
        m_en = 0; m_mode_stg = 0; m_mode_act = 0; m_phase = 0;
        m_pwm = '0; m_tick = 0; m_rd = '0;
    endtask

    task automatic m_step();
        int nphase;
        if (rst) begin
            m_reset();
            return;
        end
        nphase = m_en ? (m_phase + 1) % m_len() : 0;
        for (int i = 0; i < NUM_CH; i++) m_pwm[i] = m_en && (m_cnt() < m_duty_act[i]);
        m_tick = m_en && (nphase == 0);
        m_rd = WIDTH'(m_read(int'(rd_addr)));
        if (wr_en) begin
            if (wr_addr < NUM_CH) m_duty_stg[wr_addr] = wr_data;
            else if (wr_addr == NUM_CH) m_per_stg = wr_data;
            else if (wr_addr == NUM_CH + 1) begin
                m_en = wr_data[0];
                m_mode_stg = wr_data[1];
            end
        end
        // Reload happens when the period restarts or while disabled (old enable).
        if (nphase == 0) begin
            for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty_stg[i];
            m_per_act = m_per_stg;
            m_mode_act = m_mode_stg;
        end
        m_phase = nphase;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
        chk("pwm", 32'(pwm_out), 32'(m_pwm));
        chk("tick", 32'(period_tick), 32'(m_tick));
        chk("rd", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = WIDTH'(d);
        cycle();
        wr_en = 1'b0;
    endtask

    // Advance until a tick is seen; an expired budget counts as a failure.
    task automatic wait_tick(input string tag);
        bit seen = 0;
        for (int n = 0; n < 600 && !seen; n++) begin
            cycle();
            if (period_tick) seen = 1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int hi0, hi1, hi2, ticks, gap, last;
        m_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state and readback of every address.
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a);
            cycle();
            chk("rst_rd", 32'(rd_data), (a == NUM_CH) ? 32'hFF : 32'd0);
        end

        // Edge mode, P = 9.
        wr(NUM_CH, 9); wr(0, 3); wr(1, 0); wr(2, 10); wr(NUM_CH + 1, 1);
        wait_tick("edge_wait");
        hi0 = 0; hi1 = 0; hi2 = 0; ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            hi0 += pwm_out[0]; hi1 += pwm_out[1]; hi2 += pwm_out[2]; ticks += period_tick;
        end
        chk("edge_ch0", hi0, 6);
        chk("edge_ch1", hi1, 0);
        chk("edge_ch2", hi2, 20);
        chk("edge_ticks", ticks, 2);

        // Center mode, P = 4: tick spacing 2P.
        wr(NUM_CH + 1, 0); wr(NUM_CH, 4); wr(0, 2); wr(NUM_CH + 1, 3);
        wait_tick("ctr_wait");
        gap = 0; last = 0; ticks = 0;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            if (period_tick) begin
                gap = k - last;
                last = k;
                ticks++;
            end
        end
        chk("ctr_gap", gap, 8);
        chk("ctr_ticks", ticks, 3);

        // Mid-period and boundary duty writes in edge mode, P = 9.
        wr(NUM_CH + 1, 0); wr(NUM_CH, 9); wr(0, 3); wr(NUM_CH + 1, 1);
        wait_tick("upd_wait");
        for (int w = 0; w < 3; w++) begin
            hi0 = 0;
            for (int k = 1; k <= 10; k++) begin
                if (w == 0 && k == 4) begin
                    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'd7;
                end else if (w == 1 && k == 10) begin
                    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'd5;
                end
                cycle();
                wr_en = 1'b0;
                hi0 += pwm_out[0];
            end
            chk("upd_win", hi0, (w == 0) ? 3 : (w == 1) ? 7 : 5);
        end

        // P = 0: boundary every cycle.
        wr(NUM_CH + 1, 0); wr(NUM_CH, 0); wr(0, 1); wr(NUM_CH + 1, 1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("p0_tick", 32'(period_tick), 32'd1);
            chk("p0_ch0", 32'(pwm_out[0]), 32'd1);
        end
        wr(NUM_CH + 1, 0);
        cycle();
        chk("dis_tick", 32'(period_tick), 32'd0);
        chk("dis_pwm", 32'(pwm_out), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int a;
            rst = ($urandom_range(0, 499) == 0);
            wr_en = ($urandom_range(0, 5) == 0);
            a = $urandom_range(0, 7);
            wr_addr = AW'(a);
            if (a == NUM_CH) wr_data = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
            else if (a == NUM_CH + 1) wr_data = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(1, 3));
            else wr_data = WIDTH'($urandom_range(0, 14));
            rd_addr = AW'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0; wr_en = 1'b0;

        // Reset mid-period with a write pending: the write is dropped.
        wr(NUM_CH, 9); wr(0, 5); wr(NUM_CH + 1, 1);
        for (int k = 0; k < 4; k++) cycle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h55;
        cycle();
        rst = 1'b0; wr_en = 1'b0;
        chk("mrst_pwm", 32'(pwm_out), 32'd0);
        chk("mrst_tick", 32'(period_tick), 32'd0);
        chk("mrst_rd", 32'(rd_data), 32'd0);
        for (int a = 0; a < 6; a++) begin
            rd_addr = AW'(a);
            cycle();
            chk("mrst_rdback", 32'(rd_data), (a == NUM_CH) ? 32'hFF : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
